// File: rtl/cr_kme_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// cr_kme_fifo_wr_arb
//
// Round-robin, packet-atomic arbiter that shares the single write port of a
// KME standard FIFO wrapper between N_REQ requesters. The selected beat is
// registered into a one-entry output stage that honours the FIFO stall. A
// requester that wins keeps the port until its last beat is accepted.
//
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   req_valid      - per-requester beat valid
//   req_last       - per-requester last-beat flag (qualified by req_valid)
//   req_data       - requester i's beat at [i*DATA_W +: DATA_W]
//   req_ack        - combinational one-hot accept; transfer when valid & ack
//   fifo_in_valid  - registered write strobe to the FIFO
//   fifo_in        - registered write data
//   fifo_in_stall  - FIFO cannot accept this cycle
//   fifo_overflow  - overflow pulse from the FIFO
//   grant_id       - current owner (LOCKED) or currently selected index (IDLE)
//   busy           - high while a multi-beat packet holds the port
//   err_overflow   - sticky overflow flag, cleared only by reset
//   pkt_cnt        - count of accepted last beats, wraps at 16 bits
// ---------------------------------------------------------------------------
module cr_kme_fifo_wr_arb #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 1,
    parameter int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ack,
    output logic                    fifo_in_valid,
    output logic [DATA_W-1:0]       fifo_in,
    input  logic                    fifo_in_stall,
    input  logic                    fifo_overflow,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    busy,
    output logic                    err_overflow,
    output logic [15:0]             pkt_cnt
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                fifo_in_valid_q, fifo_in_valid_d;
    logic [DATA_W-1:0]   fifo_in_q, fifo_in_d;
    logic                err_overflow_q, err_overflow_d;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d;

    logic                load_en;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    int                  cand;
    logic [N_REQ-1:0]    ack_c;
    logic                accept;
    logic [IDX_W-1:0]    acc_idx;
    logic [DATA_W-1:0]   acc_beat;
    logic                acc_last;

    // Wrap-around increment for the round-robin pointer; N_REQ need not be
    // a power of two, so the wrap is explicit rather than relying on overflow.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) == N_REQ - 1) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    // The output stage can take a new beat when it is empty or draining.
    assign load_en = !fifo_in_valid_q || !fifo_in_stall;

    // Round-robin scan starting at rr_ptr: the first valid requester found
    // walking upward (with wrap) is the IDLE candidate.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % N_REQ;
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    // Accept generation. In IDLE the scan winner is acked; in LOCKED only
    // the owner may be acked, so other requesters stay blocked even while
    // the owner is bubbling. Nothing is acked during reset.
    always_comb begin
        ack_c = '0;
        if (!rst && load_en) begin
            if (state_q == ST_LOCKED) begin
                if (req_valid[owner_q]) begin
                    ack_c[owner_q] = 1'b1;
                end
            end else begin
                if (sel_found) begin
                    ack_c[sel_idx] = 1'b1;
                end
            end
        end
    end

    // The acked index is either the owner or the scan winner; ack_c is only
    // ever set where req_valid is high, so any set bit means a transfer.
    always_comb begin
        acc_idx  = (state_q == ST_LOCKED) ? owner_q : sel_idx;
        accept   = |ack_c;
        acc_beat = req_data[int'(acc_idx)*DATA_W +: DATA_W];
        acc_last = req_last[acc_idx];
    end

    // Next-state logic for the FSM, output stage, pointer and counters.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        pkt_cnt_d       = pkt_cnt_q;
        fifo_in_valid_d = fifo_in_valid_q;
        fifo_in_d       = fifo_in_q;
        err_overflow_d  = err_overflow_q || fifo_overflow;

        if (accept) begin
            fifo_in_d       = acc_beat;
            fifo_in_valid_d = 1'b1;
            if (acc_last) begin
                // Packet complete: release the port and move priority on
                // past whoever just finished.
                state_d   = ST_IDLE;
                rr_ptr_d  = next_idx(acc_idx);
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end else begin
                state_d = ST_LOCKED;
                owner_d = acc_idx;
            end
        end else if (!fifo_in_stall) begin
            fifo_in_valid_d = 1'b0;
        end
    end

    // State registers. Reset drops any lock and discards the held beat;
    // it also wins over a simultaneous overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            owner_q         <= '0;
            rr_ptr_q        <= '0;
            pkt_cnt_q       <= '0;
            fifo_in_valid_q <= 1'b0;
            fifo_in_q       <= '0;
            err_overflow_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            rr_ptr_q        <= rr_ptr_d;
            pkt_cnt_q       <= pkt_cnt_d;
            fifo_in_valid_q <= fifo_in_valid_d;
            fifo_in_q       <= fifo_in_d;
            err_overflow_q  <= err_overflow_d;
        end
    end

    // Status outputs. In IDLE grant_id shows the scan winner, or 0 when
    // nobody is requesting.
    always_comb begin
        req_ack       = ack_c;
        fifo_in_valid = fifo_in_valid_q;
        fifo_in       = fifo_in_q;
        busy          = (state_q == ST_LOCKED);
        err_overflow  = err_overflow_q;
        pkt_cnt       = pkt_cnt_q;
        if (state_q == ST_LOCKED) begin
            grant_id = owner_q;
        end else if (sel_found) begin
            grant_id = sel_idx;
        end else begin
            grant_id = '0;
        end
    end

endmodule

// File: tb/tb_cr_kme_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_cr_kme_fifo_wr_arb
//
// Directed scenarios followed by a randomized run, all checked cycle by cycle
// against a behavioural model of the arbiter kept in this module.
// ---------------------------------------------------------------------------
module tb_cr_kme_fifo_wr_arb;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ack;
    logic            fifo_in_valid;
    logic [W-1:0]    fifo_in;
    logic            fifo_in_stall;
    logic            fifo_overflow;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            err_overflow;
    logic [15:0]     pkt_cnt;

    int checks   = 0;
    int failures = 0;

    // Model state
    bit        m_valid;
    int        m_data;
    int        m_rr;
    int        m_owner;
    bit        m_locked;
    int        m_pkt;
    bit        m_err;
    int        m_ack_idx;

    cr_kme_fifo_wr_arb #(
        .N_REQ (N),
        .DATA_W(W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .fifo_in_valid(fifo_in_valid),
        .fifo_in      (fifo_in),
        .fifo_in_stall(fifo_in_stall),
        .fifo_overflow(fifo_overflow),
        .grant_id     (grant_id),
        .busy         (busy),
        .err_overflow (err_overflow),
        .pkt_cnt      (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l,
                                 input logic [N*W-1:0] d, input logic st,
                                 input logic ov, input logic rs);
        req_valid     = v;
        req_last      = l;
        req_data      = d;
        fifo_in_stall = st;
        fifo_overflow = ov;
        rst           = rs;
    endtask

    task automatic modelReset();
        m_valid  = 0;
        m_data   = 0;
        m_rr     = 0;
        m_owner  = 0;
        m_locked = 0;
        m_pkt    = 0;
        m_err    = 0;
    endtask

    // Predicts this cycle's accept from the arbitration rules and compares
    // every output against the model.
    task automatic checkOutput();
        bit load;
        int sel;
        int exp_grant;
        int exp_ack;
        sel = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (sel < 0 && req_valid[c]) sel = c;
        end
        load = !m_valid || !fifo_in_stall;
        m_ack_idx = -1;
        if (!rst && load) begin
            if (m_locked) begin
                if (req_valid[m_owner]) m_ack_idx = m_owner;
            end else if (sel >= 0) begin
                m_ack_idx = sel;
            end
        end
        exp_ack   = (m_ack_idx >= 0) ? (1 << m_ack_idx) : 0;
        exp_grant = m_locked ? m_owner : ((sel >= 0) ? sel : 0);
        expectEq("req_ack",       32'(req_ack),       32'(exp_ack));
        expectEq("grant_id",      32'(grant_id),      32'(exp_grant));
        expectEq("busy",          32'(busy),          32'(m_locked));
        expectEq("fifo_in_valid", 32'(fifo_in_valid), 32'(m_valid));
        expectEq("fifo_in",       32'(fifo_in),       32'(m_data));
        expectEq("err_overflow",  32'(err_overflow),  32'(m_err));
        expectEq("pkt_cnt",       32'(pkt_cnt),       32'(m_pkt));
    endtask

    task automatic modelUpdate();
        if (rst) begin
            modelReset();
        end else begin
            if (m_ack_idx >= 0) begin
                m_valid = 1;
                m_data  = int'(req_data[m_ack_idx*W +: W]);
                if (req_last[m_ack_idx]) begin
                    m_locked = 0;
                    m_rr     = (m_ack_idx + 1) % N;
                    m_pkt    = (m_pkt + 1) % 65536;
                end else begin
                    m_locked = 1;
                    m_owner  = m_ack_idx;
                end
            end else if (!fifo_in_stall) begin
                m_valid = 0;
            end
            if (fifo_overflow) m_err = 1;
        end
    endtask

    // One clock: check outputs mid-cycle, advance model, cross the edge.
    task automatic tick();
        #2;
        checkOutput();
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        modelReset();
        tick();

        // Single-beat packet from requester 2
        applyStimulus(4'b0100, 4'b0100, 16'h0A00, 1'b0, 1'b0, 1'b0);
        #1;
        expectEq("single_ack", 32'(req_ack), 32'h4);
        tick();
        expectEq("single_data",  32'(fifo_in),       32'hA);
        expectEq("single_valid", 32'(fifo_in_valid), 32'h1);
        expectEq("single_pkt",   32'(pkt_cnt),       32'h1);
        applyStimulus(4'b1111, 4'b1111, 16'hDCBA, 1'b0, 1'b0, 1'b0);
        #1;
        expectEq("rr_after_2", 32'(grant_id), 32'h3);

        // Reset, then all requesters stream single-beat packets
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 4'b1111, 16'hDCBA, 1'b0, 1'b0, 1'b0);
            #1;
            expectEq("rr_order", 32'(req_ack), 32'(1 << (k % 4)));
            tick();
            expectEq("rr_stream_valid", 32'(fifo_in_valid), 32'h1);
        end
        expectEq("rr_pkt8", 32'(pkt_cnt), 32'd8);

        // Move priority to requester 1, then a 3-beat packet with a bubble
        applyStimulus(4'b0001, 4'b0001, 16'hDCBA, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0011, 4'b0000, 16'hDCBA, 1'b0, 1'b0, 1'b0);
        #1;
        expectEq("lock_first", 32'(req_ack), 32'h2);
        tick();
        applyStimulus(4'b0001, 4'b0000, 16'hDCBA, 1'b0, 1'b0, 1'b0);
        #1;
        expectEq("lock_bubble_ack",  32'(req_ack), 32'h0);
        expectEq("lock_bubble_busy", 32'(busy),    32'h1);
        tick();
        applyStimulus(4'b0011, 4'b0000, 16'hDCBA, 1'b0, 1'b0, 1'b0);
        #1;
        expectEq("lock_mid", 32'(req_ack), 32'h2);
        tick();
        applyStimulus(4'b0011, 4'b0010, 16'hDCBA, 1'b0, 1'b0, 1'b0);
        #1;
        expectEq("lock_last", 32'(req_ack), 32'h2);
        tick();
        applyStimulus(4'b1001, 4'b1001, 16'hDCBA, 1'b0, 1'b0, 1'b0);
        #1;
        expectEq("after_lock", 32'(req_ack), 32'h8);
        tick();

        // Stall with a beat held in the output stage
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1111, 4'b1111, 16'h1234, 1'b1, 1'b0, 1'b0);
            #1;
            expectEq("stall_ack",   32'(req_ack),       32'h0);
            expectEq("stall_valid", 32'(fifo_in_valid), 32'h1);
            expectEq("stall_data",  32'(fifo_in),       32'hD);
            tick();
        end
        applyStimulus(4'b1111, 4'b1111, 16'h1234, 1'b0, 1'b0, 1'b0);
        #1;
        expectEq("stall_release", 32'(req_ack), 32'h1);
        tick();

        // Overflow pulse is sticky
        applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        expectEq("ovf_sticky", 32'(err_overflow), 32'h1);

        // Reset in the middle of a packet from requester 3, with overflow
        applyStimulus(4'b1000, 4'b0000, 16'h7000, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        expectEq("mid_busy", 32'(busy), 32'h1);
        applyStimulus(4'b1000, 4'b0000, 16'h7000, 1'b0, 1'b1, 1'b1);
        #1;
        expectEq("rst_ack", 32'(req_ack), 32'h0);
        tick();
        expectEq("rst_busy",  32'(busy),          32'h0);
        expectEq("rst_valid", 32'(fifo_in_valid), 32'h0);
        expectEq("rst_err",   32'(err_overflow),  32'h0);
        applyStimulus(4'b1111, 4'b0000, 16'h4321, 1'b0, 1'b0, 1'b0);
        #1;
        expectEq("rst_first_grant", 32'(req_ack), 32'h1);
        tick();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            applyStimulus(N'($urandom), N'($urandom), (N*W)'($urandom),
                          ($urandom_range(0, 99) < 30),
                          ($urandom_range(0, 99) < 3),
                          ($urandom_range(0, 99) < 2));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
